wb_ram_ctrl: RTL and testbench
==============================

Name: wb_ram_ctrl

Overview:
- Wishbone B4 classic slave that sits directly upstream of the team's generic single-port-write/registered-read RAM and drives its write-enable, write-data, write-address and read-address ports.
- Converts byte-addressed, byte-select bus transactions into whole-word RAM accesses.
- Partial-lane writes are done as read-modify-write, because the RAM has no byte enables.
- Consumes the RAM's one-cycle-latency read data and returns it on the bus with a single-cycle ack.

Parameters:
- RAM_WORDS_SIZE, 256: RAM depth in words; must match the RAM instance. AW = log2(RAM_WORDS_SIZE), using the shared helper.
- RAM_WORDS_WIDTH, 32: word width; must be a multiple of 8. SW = RAM_WORDS_WIDTH/8.
- WB_ADDR_WIDTH, 32: bus byte-address width; must be ≥ AW+2.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  synchronous active-high reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  WB_ADDR_WIDTH  byte address; word index = adr[AW+1:2]; bits [1:0] ignored
- wb_dat_i  in  RAM_WORDS_WIDTH  write data
- wb_sel_i  in  SW  byte lane selects
- wb_dat_o  out  RAM_WORDS_WIDTH  read data, registered
- wb_ack_o  out  1  transfer ack, registered
- wb_err_o  out  1  error ack, registered
- ram_we_o  out  1  to RAM we_i, registered
- ram_data_o  out  RAM_WORDS_WIDTH  to RAM data_i, registered
- ram_w_addr_o  out  AW  to RAM w_addr_i, registered
- ram_r_addr_o  out  AW  to RAM r_addr_i; combinational = adr[AW+1:2]
- ram_data_i  in  RAM_WORDS_WIDTH  from RAM data_o (valid one cycle after r_addr)

Behaviour:
- Reset: synchronous, active-high, in any state. Forces state IDLE and clears wb_dat_o, wb_ack_o, wb_err_o, ram_we_o, ram_data_o and ram_w_addr_o to 0. Reset during an RMW produces no RAM write and no ack.
- Request: req = cyc & stb. It is sampled only in IDLE. The master holds adr/dat/sel/we stable until ack or err.
- States: IDLE, RD, RMW, ACK.
- IDLE transitions:
  - req & !we goes to RD.
  - req & we & sel == all-ones: register ram_we_o = 1, ram_data_o = dat_i, ram_w_addr_o = index, wb_ack_o = 1; go to ACK. Ack latency is 1 cycle.
  - req & we & sel == 0: wb_ack_o = 1 with no RAM write; go to ACK.
  - req & we & partial sel goes to RMW.
- RD: ram_data_i is valid. Register wb_dat_o = ram_data_i and wb_ack_o = 1; go to ACK. Ack latency is 2 cycles.
- RMW: merged lane k = sel[k] ? dat_i lane k : ram_data_i lane k. Register ram_we_o = 1, ram_data_o = merged, ram_w_addr_o = index, wb_ack_o = 1; go to ACK. Ack latency is 2 cycles. The RAM commits at the end of the ACK cycle.
- ACK: ack/err are high for exactly this one cycle. Next state registers clear ack, err and ram_we_o; go to IDLE. A req present in ACK is not accepted, so back-to-back transfers are spaced by at least one IDLE cycle.
- Abort: cyc_i low while in RD or RMW returns to IDLE with no ack and no write.
- Read-after-write: a read issued in the IDLE after a write's ACK returns the new data, because the RAM write completes at the end of ACK.
- wb_dat_o holds its last read value except on reset. It is only meaningful while wb_ack_o = 1.
- Out-of-range, word index ≥ RAM_WORDS_SIZE (only possible for non-power-of-2 sizes):
  - ram_we_o is suppressed.
  - A read returns 0.
  - Ack is still given, with the same latencies as above.
- Upper address bits above AW+1 are ignored, so the RAM aliases across the address space.

Optional Feature:
- Macro WB_RAM_ERR_EN.
- Defined: any request whose adr bits [WB_ADDR_WIDTH-1:AW+2] are nonzero, or whose word index is ≥ RAM_WORDS_SIZE, gets wb_err_o = 1 instead of ack. Error latency is 1 cycle, via ACK. There is no RAM read or write, and wb_dat_o is unchanged.
- Undefined: wb_err_o is tied to 0, and aliasing and out-of-range handling are as described in Behaviour.

Test Plan:
- Reset then idle: all outputs 0; ram_we_o is never asserted with no req.
- Full write 0xDEADBEEF at adr 0x10 (sel 0xF): ack at cycle 1; RAM[4] = 0xDEADBEEF. A read of 0x10 then acks at cycle 2 with wb_dat_o = 0xDEADBEEF.
- Partial write to 0x10 with sel 0x3, dat 0x00001234, after the previous test: ack at cycle 2; RAM[4] = 0xDEAD1234. Read back returns 0xDEAD1234.
- Write with sel 0 to 0x20 holding 0x55AA55AA: ack at cycle 1, no ram_we_o pulse; RAM[8] stays 0x55AA55AA.
- Abort and reset mid-RMW:
  - Drop cyc in the RMW cycle: no ack, no write.
  - Assert rst_i in the RMW cycle: no ack, no write.
  - In both cases a following read shows the old value.
- With WB_RAM_ERR_EN, read adr 0x0001_0000 (size 256): wb_err_o pulses at cycle 1, wb_ack_o stays 0, and wb_dat_o is unchanged. Without the macro the same access acks with RAM[0] data.

Source files
------------

// File: rtl/wb_ram_ctrl_if.sv
// Wishbone B4 classic bus bundle between a master and wb_ram_ctrl.
// Signal names keep the slave-side _i/_o suffixes so they match the controller's documentation.
interface wb_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic [SEL_WIDTH-1:0]  wb_sel_i;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_ack_o;
  logic                  wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_ram_ctrl.sv
// Wishbone B4 classic slave driving a registered-read, no-byte-enable RAM.
// Partial-lane writes use read-modify-write. Define WB_RAM_ERR_EN to error-ack bad addresses.
module wb_ram_ctrl #(
  parameter  int RAM_WORDS_SIZE  = 256,
  parameter  int RAM_WORDS_WIDTH = 32,
  parameter  int WB_ADDR_WIDTH   = 32,
  localparam int AW              = $clog2(RAM_WORDS_SIZE),
  localparam int SW              = RAM_WORDS_WIDTH / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  wb_ram_ctrl_if.slave               wb,
  output logic                       ram_we_o,
  output logic [RAM_WORDS_WIDTH-1:0] ram_data_o,
  output logic [AW-1:0]              ram_w_addr_o,
  output logic [AW-1:0]              ram_r_addr_o,
  input  logic [RAM_WORDS_WIDTH-1:0] ram_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_RMW, S_ACK} state_t;

  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(RAM_WORDS_SIZE);

  state_t                     r_state;
  state_t                     w_stateNext;
  logic [RAM_WORDS_WIDTH-1:0] r_dat, w_datNext;
  logic                       r_ack, w_ackNext;
  logic                       r_err, w_errNext;
  logic                       r_ramWe, w_ramWeNext;
  logic [RAM_WORDS_WIDTH-1:0] r_ramData, w_ramDataNext;
  logic [AW-1:0]              r_wAddr, w_wAddrNext;

  logic                       w_req;
  logic [AW-1:0]              w_index;
  logic                       w_inRange;
  logic                       w_selFull;
  logic                       w_selNone;
  logic                       w_errReq;
  logic [RAM_WORDS_WIDTH-1:0] w_merged;
  logic                       w_unused;

  assign w_req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_index   = wb.wb_adr_i[AW+1:2];
  assign w_inRange = ({1'b0, w_index} < LP_DEPTH);
  assign w_selFull = &wb.wb_sel_i;
  assign w_selNone = ~|wb.wb_sel_i;
  assign w_unused  = ^wb.wb_adr_i;

`ifdef WB_RAM_ERR_EN
  assign w_errReq = w_req & ((|(wb.wb_adr_i >> (AW + 2))) | ~w_inRange);
`else
  assign w_errReq = 1'b0;
`endif

  always_comb begin
    w_merged = ram_data_i;
    for (int k = 0; k < SW; k++) begin
      if (wb.wb_sel_i[k]) w_merged[8*k +: 8] = wb.wb_dat_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_dat     <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_ramWe   <= 1'b0;
      r_ramData <= '0;
      r_wAddr   <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_dat     <= w_datNext;
      r_ack     <= w_ackNext;
      r_err     <= w_errNext;
      r_ramWe   <= w_ramWeNext;
      r_ramData <= w_ramDataNext;
      r_wAddr   <= w_wAddrNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_errReq)                    w_stateNext = S_ACK;
          else if (!wb.wb_we_i)            w_stateNext = S_RD;
          else if (w_selFull || w_selNone) w_stateNext = S_ACK;
          else                             w_stateNext = S_RMW;
        end
      end
      S_RD, S_RMW: w_stateNext = wb.wb_cyc_i ? S_ACK : S_IDLE;
      S_ACK:       w_stateNext = S_IDLE;
      default:     w_stateNext = S_IDLE;
    endcase
  end

  // Ack, err and write-enable default low so they last exactly one cycle; data/address hold.
  always_comb begin
    w_datNext     = r_dat;
    w_ackNext     = 1'b0;
    w_errNext     = 1'b0;
    w_ramWeNext   = 1'b0;
    w_ramDataNext = r_ramData;
    w_wAddrNext   = r_wAddr;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_errReq) begin
            w_errNext = 1'b1;
          end else if (wb.wb_we_i && w_selFull) begin
            w_ramWeNext   = w_inRange;
            w_ramDataNext = wb.wb_dat_i;
            w_wAddrNext   = w_index;
            w_ackNext     = 1'b1;
          end else if (wb.wb_we_i && w_selNone) begin
            w_ackNext = 1'b1;
          end
        end
      end
      S_RD: begin
        if (wb.wb_cyc_i) begin
          w_datNext = w_inRange ? ram_data_i : '0;
          w_ackNext = 1'b1;
        end
      end
      S_RMW: begin
        if (wb.wb_cyc_i) begin
          w_ramWeNext   = w_inRange;
          w_ramDataNext = w_merged;
          w_wAddrNext   = w_index;
          w_ackNext     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign wb.wb_dat_o  = r_dat;
  assign wb.wb_ack_o  = r_ack;
  assign wb.wb_err_o  = r_err;
  assign ram_we_o     = r_ramWe;
  assign ram_data_o   = r_ramData;
  assign ram_w_addr_o = r_wAddr;
  assign ram_r_addr_o = w_index;

endmodule

// File: tb/tb_wb_ram_ctrl.sv
// Self-checking bench for wb_ram_ctrl: directed scenarios plus random transfers
// checked against a word-array reference of the RAM and bus latency rules.
module tb_wb_ram_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 32;
`ifdef WB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus ();

  logic          ramWe;
  logic [DW-1:0] ramDataO;
  logic [AW-1:0] ramWAddr;
  logic [AW-1:0] ramRAddr;
  logic [DW-1:0] ramRData;

  wb_ram_ctrl #(
    .RAM_WORDS_SIZE (DEPTH),
    .RAM_WORDS_WIDTH(DW),
    .WB_ADDR_WIDTH  (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb          (bus),
    .ram_we_o    (ramWe),
    .ram_data_o  (ramDataO),
    .ram_w_addr_o(ramWAddr),
    .ram_r_addr_o(ramRAddr),
    .ram_data_i  (ramRData)
  );

  // RAM behaviour: write on the clock edge, registered read; preload port for setup.
  logic [DW-1:0] ramMem [DEPTH];
  logic          loadEn   = 1'b0;
  logic [AW-1:0] loadAddr = '0;
  logic [DW-1:0] loadData = '0;
  always @(posedge clk) begin
    if (loadEn)     ramMem[loadAddr] <= loadData;
    else if (ramWe) ramMem[ramWAddr] <= ramDataO;
    ramRData <= ramMem[ramRAddr];
  end

  int weCount  = 0;
  int ackCount = 0;
  always @(posedge clk) begin
    if (ramWe)        weCount  <= weCount + 1;
    if (bus.wb_ack_o) ackCount <= ackCount + 1;
  end

  logic [DW-1:0] refMem [DEPTH];
  logic [DW-1:0] lastDat = '0;
  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drives one request and holds it until ack/err (bounded), then leaves one IDLE cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output int lat, output logic [31:0] rdat,
                               output logic sawAck, output logic sawErr);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    lat    = 99;
    rdat   = '0;
    sawAck = 1'b0;
    sawErr = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o || bus.wb_err_o) begin
        lat    = c;
        sawAck = bus.wb_ack_o;
        sawErr = bus.wb_err_o;
        rdat   = bus.wb_dat_o;
        break;
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic doTransfer(input string tag, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
    int          lat, expLat, weBefore, expWe;
    logic [31:0] rdat;
    logic        sawAck, sawErr, expErr;
    int          idx;
    idx    = int'(adr[9:2]);
    expErr = ERR_EN && ((adr >> 10) != 0);
    if (expErr)                        expLat = 1;
    else if (!we)                      expLat = 2;
    else if (sel == 4'h0 || sel == 4'hF) expLat = 1;
    else                               expLat = 2;
    expWe    = (we && !expErr && sel != 4'h0) ? 1 : 0;
    weBefore = weCount;
    applyStimulus(we, adr, dat, sel, lat, rdat, sawAck, sawErr);
    checkOutput($sformatf("%s.lat", tag), 32'(lat), 32'(expLat));
    checkOutput($sformatf("%s.ack", tag), 32'(sawAck), 32'(!expErr));
    checkOutput($sformatf("%s.err", tag), 32'(sawErr), 32'(expErr));
    checkOutput($sformatf("%s.wePulses", tag), 32'(weCount - weBefore), 32'(expWe));
    if (expErr) begin
      checkOutput($sformatf("%s.datHeld", tag), rdat, lastDat);
    end else if (!we) begin
      lastDat = refMem[idx];
      checkOutput($sformatf("%s.rdata", tag), rdat, refMem[idx]);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (sel[k]) refMem[idx][8*k +: 8] = dat[8*k +: 8];
      end
      checkOutput($sformatf("%s.ramWord", tag), ramMem[idx], refMem[idx]);
    end
  endtask

  // Starts a partial write, then kills it during RMW by dropping cyc or by reset.
  task automatic applyAbort(input string tag, input bit useReset);
    int weBefore, ackBefore;
    weBefore  = weCount;
    ackBefore = ackCount;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 32'h14;
    bus.wb_dat_i = 32'hA5A5A5A5;
    bus.wb_sel_i = 4'h6;
    @(posedge clk); #1;
    if (useReset) rst = 1'b1;
    else begin
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    if (useReset) begin
      lastDat = '0;
      checkOutput($sformatf("%s.datCleared", tag), bus.wb_dat_o, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("%s.acks", tag), 32'(ackCount - ackBefore), 32'h0);
    checkOutput($sformatf("%s.wePulses", tag), 32'(weCount - weBefore), 32'h0);
    checkOutput($sformatf("%s.ramWord", tag), ramMem[5], refMem[5]);
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;

    for (int i = 0; i < DEPTH; i++) begin
      loadEn   = 1'b1;
      loadAddr = AW'(i);
      loadData = $urandom;
      refMem[i] = loadData;
      @(posedge clk); #1;
    end
    loadEn = 1'b0;

    checkOutput("reset.dat", bus.wb_dat_o, 32'h0);
    checkOutput("reset.ack", 32'(bus.wb_ack_o), 32'h0);
    checkOutput("reset.err", 32'(bus.wb_err_o), 32'h0);
    checkOutput("reset.ramWe", 32'(ramWe), 32'h0);
    checkOutput("reset.ramData", ramDataO, 32'h0);
    checkOutput("reset.ramWAddr", 32'(ramWAddr), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle.wePulses", 32'(weCount), 32'h0);
    checkOutput("idle.acks", 32'(ackCount), 32'h0);

    doTransfer("fullWr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checkOutput("fullWr.word4", ramMem[4], 32'hDEADBEEF);
    doTransfer("fullRd", 1'b0, 32'h10, 32'h0, 4'hF);
    doTransfer("rmwWr", 1'b1, 32'h10, 32'h00001234, 4'h3);
    checkOutput("rmwWr.word4", ramMem[4], 32'hDEAD1234);
    doTransfer("rmwRd", 1'b0, 32'h10, 32'h0, 4'hF);

    doTransfer("fillWr", 1'b1, 32'h20, 32'h55AA55AA, 4'hF);
    doTransfer("sel0Wr", 1'b1, 32'h20, 32'h12345678, 4'h0);
    checkOutput("sel0Wr.word8", ramMem[8], 32'h55AA55AA);
    doTransfer("sel0Rd", 1'b0, 32'h20, 32'h0, 4'hF);

    applyAbort("abortCyc", 1'b0);
    doTransfer("abortCycRd", 1'b0, 32'h14, 32'h0, 4'hF);
    applyAbort("abortRst", 1'b1);
    doTransfer("abortRstRd", 1'b0, 32'h14, 32'h0, 4'hF);

    doTransfer("preHiRd", 1'b0, 32'h10, 32'h0, 4'hF);
    doTransfer("hiAdrRd", 1'b0, 32'h0001_0000, 32'h0, 4'hF);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] adr;
      logic [31:0] upper;
      upper = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      adr   = (upper << 10) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      doTransfer($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), adr, $urandom,
                 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
